// File: rtl/odd_div_pkg.sv
// Shared types and helpers for the odd-ratio divider monitor.
//  state_t     : monitor FSM states
//  good_period : grades one measured period against the expected ratio n
package odd_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    // A period is good when its length is exactly n and the high time is
    // floor(n/2) or ceil(n/2), so odd ratios accept either split.
    function automatic logic good_period(input int unsigned cnt,
                                         input int unsigned hcnt,
                                         input int unsigned n);
        return (cnt == n) && ((hcnt == n / 2) || (hcnt == (n + 1) / 2));
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer plus rising-edge detect for an asynchronous level.
//  clk_in : sampling clock
//  rst    : asynchronous reset, active-high
//  d      : asynchronous input
//  s      : synchronized level, aligned with rise
//  rise   : one-cycle pulse on a synchronized 0->1 transition
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [STAGES-1:0] sync_q;

    // s is a delayed copy of the last synchronizer stage so the level and
    // the rise pulse arrive in the same cycle.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s      <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            s      <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~s;
        end
    end

endmodule

// File: rtl/odd_div_monitor.sv
// Receive-side checker for a divided clock. Measures period and high time
// in clk_in cycles, declares lock after LOCK_CNT consecutive good periods,
// and flags ratio/duty/stuck faults.
//  clk_in   : source clock
//  rst      : asynchronous reset, active-high
//  clk_div  : divided clock under test (asynchronous data)
//  en       : monitor enable
//  period_o : last measured period
//  high_o   : last measured high count
//  locked   : LOCK_CNT consecutive good periods seen
//  err      : one-cycle pulse per fault
//  err_cnt  : saturating fault count
module odd_div_monitor
    import odd_div_pkg::*;
#(
    parameter int unsigned DIV_N       = 7,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             en,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(2 * DIV_N);
    localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic             s;
    logic             rise;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [MW-1:0]    match;

    logic [CNT_W-1:0] cnt_inc_c;
    logic [CNT_W-1:0] hcnt_inc_c;
    logic [MW-1:0]    match_inc_c;
    logic [ERR_W-1:0] err_inc_c;
    logic             good_c;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (clk_div),
        .s      (s),
        .rise   (rise)
    );

    // Saturating increments and the grade of the period ending this cycle.
    always_comb begin
        cnt_inc_c   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        hcnt_inc_c  = (s && (hcnt != CNT_MAX)) ? hcnt + CNT_ONE : hcnt;
        match_inc_c = (match == LOCK_TGT) ? match : match + MW'(1);
        err_inc_c   = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);
        good_c      = good_period(32'(cnt), 32'(hcnt), DIV_N);
    end

    // FSM, counters, grading and fault counting.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hcnt     <= '0;
            match    <= '0;
            period_o <= '0;
            high_o   <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err <= 1'b0;
            if (!en) begin
                // Abandon any partial period silently.
                state  <= IDLE;
                cnt    <= '0;
                hcnt   <= '0;
                match  <= '0;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt    <= '0;
                        hcnt   <= '0;
                        match  <= '0;
                        locked <= 1'b0;
                        state  <= ALIGN;
                    end
                    ALIGN: begin
                        locked <= 1'b0;
                        match  <= '0;
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            hcnt  <= CNT_ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE, LOCKED: begin
                        if (rise) begin
                            // Rise wins over a coincident timeout.
                            period_o <= cnt;
                            high_o   <= hcnt;
                            cnt      <= CNT_ONE;
                            hcnt     <= CNT_ONE;
                            if (good_c) begin
                                match <= match_inc_c;
                                if (match_inc_c == LOCK_TGT) begin
                                    locked <= 1'b1;
                                    state  <= LOCKED;
                                end
                            end else begin
                                err     <= 1'b1;
                                err_cnt <= err_inc_c;
                                match   <= '0;
                                locked  <= 1'b0;
                                state   <= MEASURE;
                            end
                        end else if (cnt == TIMEOUT) begin
                            // Stuck input: one fault, then re-align.
                            err     <= 1'b1;
                            err_cnt <= err_inc_c;
                            match   <= '0;
                            locked  <= 1'b0;
                            cnt     <= '0;
                            hcnt    <= '0;
                            state   <= ALIGN;
                        end else begin
                            cnt  <= cnt_inc_c;
                            hcnt <= hcnt_inc_c;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_odd_div_monitor.sv
// Scoreboard bench for odd_div_monitor: stimulus pushes expected err and
// locked events, a forked monitor pops and compares them as they appear.
module tb_odd_div_monitor;

    logic       clk_in;
    logic       rst;
    logic       clk_div;
    logic       en;
    logic [7:0] period_o;
    logic [7:0] high_o;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    typedef struct {
        int ecnt;
        int per;
        int hi;
        int rise;
    } err_exp_t;

    typedef struct {
        int val;
        int rise;
    } lock_exp_t;

    err_exp_t  err_q[$];
    lock_exp_t lock_q[$];

    int n_vec  = 0;
    int n_bad  = 0;
    int rise_drv = 0;

    odd_div_monitor #(
        .DIV_N       (7),
        .CNT_W       (8),
        .LOCK_CNT    (4),
        .SYNC_STAGES (2),
        .ERR_W       (8)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .clk_div  (clk_div),
        .en       (en),
        .period_o (period_o),
        .high_o   (high_o),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_err(input int ecnt, input int per, input int hi, input int rise);
        err_exp_t e;
        e.ecnt = ecnt; e.per = per; e.hi = hi; e.rise = rise;
        err_q.push_back(e);
    endtask

    task automatic push_lock(input int val, input int rise);
        lock_exp_t l;
        l.val = val; l.rise = rise;
        lock_q.push_back(l);
    endtask

    // cnt periods of ratio n with h high cycles, driven on the falling edge
    task automatic gen(input int n, input int h, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk_in);
            clk_div = 1'b1;
            rise_drv++;
            repeat (h - 1) @(negedge clk_in);
            @(negedge clk_in);
            clk_div = 1'b0;
            repeat (n - h - 1) @(negedge clk_in);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, int'(period_o), 0);
        chk({tag, "_high"},   int'(high_o),   0);
        chk({tag, "_locked"}, int'(locked),   0);
        chk({tag, "_err"},    int'(err),      0);
        chk({tag, "_errcnt"}, int'(err_cnt),  0);
    endtask

    task automatic chk_state(input string tag, input int lk, input int ec, input int per, input int hi);
        chk({tag, "_locked"}, int'(locked),   lk);
        chk({tag, "_errcnt"}, int'(err_cnt),  ec);
        chk({tag, "_period"}, int'(period_o), per);
        chk({tag, "_high"},   int'(high_o),   hi);
    endtask

    // Pops expectations whenever err pulses or locked changes.
    task automatic monitor();
        int pl;
        int pe;
        err_exp_t  e;
        lock_exp_t l;
        pl = 0;
        pe = 0;
        forever begin
            @(negedge clk_in);
            #1;
            if (err) begin
                chk("err_width", pe, 0);
                if (err_q.size() == 0) begin
                    chk("err_unexpected", int'(err), 0);
                end else begin
                    e = err_q.pop_front();
                    chk("err_errcnt", int'(err_cnt),  e.ecnt);
                    chk("err_period", int'(period_o), e.per);
                    chk("err_high",   int'(high_o),   e.hi);
                    chk("err_rise",   rise_drv,       e.rise);
                end
            end
            if (int'(locked) != pl) begin
                if (lock_q.size() == 0) begin
                    chk("lock_unexpected", int'(locked), pl);
                end else begin
                    l = lock_q.pop_front();
                    chk("lock_value", int'(locked), l.val);
                    if (l.rise >= 0) chk("lock_rise", rise_drv, l.rise);
                end
            end
            pl = int'(locked);
            pe = int'(err);
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        clk_div = 1'b0;
        fork
            monitor();
        join_none

        // reset values
        repeat (3) @(negedge clk_in);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk_in);
        chk_zero("post_reset");

        // 1: ideal /7, both legal duty splits, lock on the 5th rise
        en = 1'b1;
        @(negedge clk_in);
        rise_drv = 0;
        push_lock(1, 5);
        gen(7, 3, 4);
        gen(7, 4, 4);
        chk_state("t1", 1, 0, 7, 4);

        // 2: switch to /6; first rise still closes a /7 period
        rise_drv = 0;
        push_err(1, 6, 3, 2);
        push_lock(0, 2);
        push_err(2, 6, 3, 3);
        push_err(3, 6, 3, 4);
        gen(6, 3, 4);
        chk_state("t2", 0, 3, 6, 3);
        rise_drv = 0;
        push_err(4, 6, 3, 1);
        push_lock(1, 5);
        gen(7, 3, 6);
        chk_state("t2_relock", 1, 4, 7, 3);

        // 3: stuck low, one timeout fault, outputs hold last period
        rise_drv = 0;
        push_err(5, 7, 3, 0);
        push_lock(0, 0);
        repeat (20) @(negedge clk_in);
        chk_state("t3", 0, 5, 7, 3);
        rise_drv = 0;
        push_lock(1, 5);
        gen(7, 3, 6);
        chk_state("t3_relock", 1, 5, 7, 3);

        // 4: /7 with 2-cycle high time, never locks
        rise_drv = 0;
        push_err(6, 7, 2, 2);
        push_lock(0, 2);
        push_err(7, 7, 2, 3);
        push_err(8, 7, 2, 4);
        gen(7, 2, 4);
        chk_state("t4", 0, 8, 7, 2);
        rise_drv = 0;
        push_err(9, 7, 2, 1);
        push_lock(1, 5);
        gen(7, 3, 6);
        chk_state("t4_relock", 1, 9, 7, 3);

        // 5: reset while locked
        push_lock(0, -1);
        @(negedge clk_in);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk_zero("t5_in_reset");
        end
        rst = 1'b0;
        @(negedge clk_in);
        chk_zero("t5_released");
        rise_drv = 0;
        push_lock(1, 5);
        gen(7, 3, 6);
        chk_state("t5_relock", 1, 0, 7, 3);

        // 6: drop enable while locked
        push_lock(0, -1);
        @(negedge clk_in);
        en = 1'b0;
        @(negedge clk_in);
        chk("t6_unlock", int'(locked), 0);
        repeat (9) @(negedge clk_in);
        chk_state("t6_idle", 0, 0, 7, 3);
        en = 1'b1;
        @(negedge clk_in);
        rise_drv = 0;
        push_lock(1, 5);
        gen(7, 3, 6);
        chk_state("t6_relock", 1, 0, 7, 3);

        repeat (5) @(negedge clk_in);
        chk("err_q_left",  err_q.size(),  0);
        chk("lock_q_left", lock_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
